csr_unit: RTL
=============

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter NUM_HPM, 4: number of mhpmcounter3.. counters and their high halves; legal range 0..29.
REQ-002 Parameter RESET_MTVEC, 32'h1000_0000: mtvec value after reset.
REQ-003 Parameter MHARTID, 0: constant read value of mhartid.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  1  CSR instruction issue strobe, one cycle per instruction.
REQ-007 req_op_i  in  3  funct3 (FUNCT3_CSRRW..FUNCT3_CSRRCI).
REQ-008 req_addr_i  in  12  CSR address.
REQ-009 req_rs1_i  in  5  rs1 index, or zimm for immediate forms.
REQ-010 req_src_i  in  32  rs1 register value; ignored for immediate forms.
REQ-011 resp_valid_o  out  1  response strobe.
REQ-012 resp_rdata_o  out  32  old CSR value, destined for rd.
REQ-013 resp_illegal_o  out  1  access raises illegal-instruction.
REQ-014 trap_i, trap_cause_i[31:0], trap_pc_i[31:0], trap_val_i[31:0]  in  trap entry strobe and data.
REQ-015 mret_i  in  1  MRET retire strobe.
REQ-016 instret_i  in  1  one instruction retired this cycle.
REQ-017 hpm_event_i  in  NUM_HPM  per-counter event, one bit per counter.
REQ-018 irq_msip_i, irq_mtip_i, irq_meip_i  in  1 each  level interrupt sources.
REQ-019 mtvec_o, mepc_o  out  32  current register values.
REQ-020 irq_pending_o  out  1  mstatus.MIE & |(mie & mip).

Function
REQ-021 Supported CSRs: mstatus (MIE, MPIE; MPP reads 2'b11), mie, mip (read-only), mtvec (direct mode, bits[1:0] read 0), mscratch, mepc (bits[1:0] read 0), mcause, mtval, mhartid, mcycle/h, minstret/h, mhpmcounterN/h, mcountinhibit.
REQ-022 Latency: resp_valid_o exactly one cycle after req_valid_i; rdata is the value before this instruction's write.
REQ-023 Operand: register forms use req_src_i; immediate forms use zero-extended req_rs1_i.
REQ-024 Write value: RW = operand; RS = old | operand; RC = old & ~operand.
REQ-025 RS/RC/RSI/RCI with req_rs1_i == 0 perform no write; RW/RWI always write.
REQ-026 Illegal when: unknown address, unimplemented counter index, or a write to a read-only CSR (address bits[11:10] == 2'b11). Illegal accesses cause no state change; rdata is 0.
REQ-027 Counters are 64-bit and split into low/high 32-bit halves. Each counter increments when its source is active and its mcountinhibit bit is clear: mcycle every cycle, minstret on instret_i, hpm on its hpm_event_i bit.
REQ-028 Counter wrap: 64'hFFFF_FFFF_FFFF_FFFF + 1 = 0; carry propagates from low half to high half in the same cycle.
REQ-029 A CSR write to a counter half in the same cycle as an increment: the written value is stored, the increment is dropped for that cycle, and the other half is unchanged.
REQ-030 Trap entry: mepc <= {trap_pc_i[31:2], 2'b00}; mcause <= trap_cause_i; mtval <= trap_val_i; MPIE <= MIE; MIE <= 0.
REQ-031 MRET: MIE <= MPIE; MPIE <= 1.
REQ-032 Priority within one cycle: trap_i > mret_i > CSR write. The losing write is discarded, and its response is still issued with the pre-trap rdata.
REQ-033 mip is sampled every cycle: MSIP bit 3, MTIP bit 7, MEIP bit 11.

Reset
REQ-034 While rst_ni is low: mstatus = 0, mie = 0, mepc = 0, mcause = 0, mtval = 0, mscratch = 0, all counters = 0, mcountinhibit = 0, mtvec = RESET_MTVEC, resp_valid_o = 0, resp_rdata_o = 0, resp_illegal_o = 0.
REQ-035 A request in flight when reset asserts produces no response.

Structure
REQ-036 New CSR addresses (mcountinhibit, mhpmcounter*, mhpmcounter*h) and mstatus/mip bit positions go in params.vh, alongside the existing CSR_* and FUNCT3_* constants.
REQ-037 Sub-module csr_counter (64-bit, inhibit, increment, split-half write) is instantiated 2+NUM_HPM times via generate.

Verification
REQ-038 mepc = 0, CSRRW rs1 value 32'h0000_00B3 -> rdata 0, mepc = 32'h0000_00B0; a repeat of the same access -> rdata 32'h0000_00B0.
REQ-039 mepc = 32'h1010_0000, CSRRS src 32'h1100_0000 -> rdata 32'h1010_0000, mepc = 32'h1110_0000; CSRRCI zimm 0 -> mepc unchanged.
REQ-040 CSRRW to mhartid (0xF14) -> resp_illegal_o = 1, rdata 0; CSRRS mhartid rs1 = 0 -> legal, rdata MHARTID.
REQ-041 mcycle written to 32'hFFFF_FFFF with mcycleh = 0 -> the next cycle reads mcycle = 0, mcycleh = 1; mcountinhibit bit 0 set -> mcycle frozen.
REQ-042 MIE = 1, trap_i with cause 32'h8000_0007, pc 32'h1000_0012 -> mepc = 32'h1000_0010, MIE = 0, MPIE = 1; mret_i -> MIE = 1.
REQ-043 trap_i coincident with a CSRRW to mscratch -> mscratch unchanged, resp_valid_o = 1; NUM_HPM = 0 build: mhpmcounter3 access -> illegal.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// Shared CSR addresses, funct3 encodings and mstatus/mip bit positions for the
// machine-mode CSR unit and its counters.
package csr_unit_pkg;

    localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam logic [31:0] MSTATUS_MPP      = 32'h0000_1800;
    localparam int          MIP_MSIP_BIT     = 3;
    localparam int          MIP_MTIP_BIT     = 7;
    localparam int          MIP_MEIP_BIT     = 11;
    localparam logic [31:0] MIE_MASK         = 32'h0000_0888;

    // mcountinhibit: CY (bit 0), IR (bit 2) and one bit per implemented hpm counter.
    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        inhibit_mask = 32'h0000_0005 | (((32'h1 << num_hpm) - 32'h1) << 3);
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// CSR instruction request/response channel between the pipeline and csr_unit.
interface csr_unit_if;
    import csr_unit_pkg::*;

    // No backpressure: every cycle with req_valid_i high is one accepted
    // instruction, answered by exactly one resp_valid_o pulse one cycle later.
    logic        req_valid_i;
    logic [2:0]  req_op_i;
    logic [11:0] req_addr_i;
    logic [4:0]  req_rs1_i;
    logic [31:0] req_src_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_illegal_o;

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_rs1_i, req_src_i,
        input  resp_valid_o, resp_rdata_o, resp_illegal_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_rs1_i, req_src_i,
        output resp_valid_o, resp_rdata_o, resp_illegal_o
    );

endinterface

// File: rtl/csr_unit_counter.sv
// 64-bit event counter with inhibit and independently writable 32-bit halves.
module csr_counter
    import csr_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inhibit_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    // A write to either half wins over the increment; the other half holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (wr_lo_i) begin
            count_o[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            count_o[63:32] <= wdata_i;
        end else if (inc_i && !inhibit_i) begin
            count_o <= count_o + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: decode/read-modify-write of CSR instructions, trap
// entry and MRET bookkeeping, interrupt pending, and the hardware counters.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int          NUM_HPM     = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h1000_0000,
    parameter logic [31:0] MHARTID     = 32'h0000_0000,
    localparam int         HPM_W       = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    csr_unit_if.slave        bus,
    input  logic             trap_i,
    input  logic [31:0]      trap_cause_i,
    input  logic [31:0]      trap_pc_i,
    input  logic [31:0]      trap_val_i,
    input  logic             mret_i,
    input  logic             instret_i,
    input  logic [HPM_W-1:0] hpm_event_i,
    input  logic             irq_msip_i,
    input  logic             irq_mtip_i,
    input  logic             irq_meip_i,
    output logic [31:0]      mtvec_o,
    output logic [31:0]      mepc_o,
    output logic             irq_pending_o
);

    localparam int          NUM_CNT      = 3 + NUM_HPM;
    localparam logic [31:0] INHIBIT_MASK = inhibit_mask(NUM_HPM);

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] mcountinhibit_q;
    logic [63:0] cnt_q [NUM_CNT];

    logic [31:0] operand, old_val, wr_val, mstatus_rd, cnt_half;
    logic [4:0]  cnt_idx;
    logic        cnt_lo_sel, cnt_hi_sel, cnt_impl;
    logic        op_ok, do_write, legal, csr_we;

    assign cnt_idx    = bus.req_addr_i[4:0];
    assign cnt_lo_sel = (bus.req_addr_i[11:5] == CSR_MCYCLE[11:5]);
    assign cnt_hi_sel = (bus.req_addr_i[11:5] == CSR_MCYCLEH[11:5]);
    // Index 1 is the time CSR, which lives outside this unit.
    assign cnt_impl   = (cnt_idx != 5'd1) && (int'(cnt_idx) < NUM_CNT);

    assign operand  = bus.req_op_i[2] ? {27'd0, bus.req_rs1_i} : bus.req_src_i;
    assign op_ok    = (bus.req_op_i[1:0] != 2'b00);
    assign do_write = (bus.req_op_i[1:0] == 2'b01) || (bus.req_rs1_i != 5'd0);

    always_comb begin
        mstatus_rd                   = MSTATUS_MPP;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    always_comb begin
        cnt_half = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_idx == 5'(i)) cnt_half = cnt_hi_sel ? cnt_q[i][63:32] : cnt_q[i][31:0];
        end
    end

    always_comb begin
        old_val = '0;
        legal   = op_ok;
        case (bus.req_addr_i)
            CSR_MSTATUS:       old_val = mstatus_rd;
            CSR_MIE:           old_val = mie_q;
            CSR_MIP:           old_val = mip_q;
            CSR_MTVEC:         old_val = mtvec_q;
            CSR_MSCRATCH:      old_val = mscratch_q;
            CSR_MEPC:          old_val = mepc_q;
            CSR_MCAUSE:        old_val = mcause_q;
            CSR_MTVAL:         old_val = mtval_q;
            CSR_MHARTID:       old_val = MHARTID;
            CSR_MCOUNTINHIBIT: old_val = mcountinhibit_q;
            default: begin
                if ((cnt_lo_sel || cnt_hi_sel) && cnt_impl) old_val = cnt_half;
                else                                        legal   = 1'b0;
            end
        endcase
        if (bus.req_addr_i[11:10] == 2'b11 && do_write) legal = 1'b0;
    end

    always_comb begin
        wr_val = operand;
        case (bus.req_op_i[1:0])
            2'b10:   wr_val = old_val | operand;
            2'b11:   wr_val = old_val & ~operand;
            default: wr_val = operand;
        endcase
    end

    // Trap entry and MRET both pre-empt a same-cycle CSR write.
    assign csr_we = bus.req_valid_i && legal && do_write && !trap_i && !mret_i;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        if (i == 1) begin : g_time
            assign cnt_q[i] = '0;
        end else begin : g_real
            logic inc;
            if (i == 0) begin : g_cyc
                assign inc = 1'b1;
            end else if (i == 2) begin : g_ret
                assign inc = instret_i;
            end else begin : g_hpm
                assign inc = hpm_event_i[i-3];
            end
            csr_counter u_counter (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .inhibit_i (mcountinhibit_q[i]),
                .inc_i     (inc),
                .wr_lo_i   (csr_we && cnt_lo_sel && (cnt_idx == 5'(i))),
                .wr_hi_i   (csr_we && cnt_hi_sel && (cnt_idx == 5'(i))),
                .wdata_i   (wr_val),
                .count_o   (cnt_q[i])
            );
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mip_q           <= '0;
            mtvec_q         <= RESET_MTVEC;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mip_q <= '0;
            mip_q[MIP_MSIP_BIT] <= irq_msip_i;
            mip_q[MIP_MTIP_BIT] <= irq_mtip_i;
            mip_q[MIP_MEIP_BIT] <= irq_meip_i;
            if (trap_i) begin
                mepc_q         <= {trap_pc_i[31:2], 2'b00};
                mcause_q       <= trap_cause_i;
                mtval_q        <= trap_val_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_i) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_we) begin
                case (bus.req_addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= wr_val[MSTATUS_MIE_BIT];
                        mstatus_mpie_q <= wr_val[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:           mie_q           <= wr_val & MIE_MASK;
                    CSR_MTVEC:         mtvec_q         <= {wr_val[31:2], 2'b00};
                    CSR_MSCRATCH:      mscratch_q      <= wr_val;
                    CSR_MEPC:          mepc_q          <= {wr_val[31:2], 2'b00};
                    CSR_MCAUSE:        mcause_q        <= wr_val;
                    CSR_MTVAL:         mtval_q         <= wr_val;
                    CSR_MCOUNTINHIBIT: mcountinhibit_q <= wr_val & INHIBIT_MASK;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.resp_valid_o   <= 1'b0;
            bus.resp_rdata_o   <= '0;
            bus.resp_illegal_o <= 1'b0;
        end else begin
            bus.resp_valid_o   <= bus.req_valid_i;
            bus.resp_illegal_o <= bus.req_valid_i && !legal;
            if (bus.req_valid_i) bus.resp_rdata_o <= legal ? old_val : 32'd0;
        end
    end

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = mstatus_mie_q && |(mie_q & mip_q);

endmodule
